// File: rtl/z16_pkg.sv
// Shared Z16 definitions: instruction width and program-loader state encoding.
package z16_pkg;

  localparam int unsigned Z16_INSTR_W = 16;

  typedef enum logic [2:0] {
    LD_LEN_LO,
    LD_LEN_HI,
    LD_DAT_LO,
    LD_DAT_HI,
    LD_CSUM,
    LD_DONE,
    LD_ERR
  } ld_state_e;

endpackage

// File: rtl/z16_program_loader.sv
// Framed byte-stream loader: assembles little-endian 16-bit words into instruction RAM
// and holds the CPU in reset until a frame with a good checksum has been written.
module z16_program_loader
  import z16_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned ADDR_W    = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [7:0]             i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_restart,
  output logic                   o_we,
  output logic [ADDR_W-1:0]      o_waddr,
  output logic [Z16_INSTR_W-1:0] o_wdata,
  output logic                   o_cpu_rst,
  output logic                   o_done,
  output logic                   o_err
);

  localparam int unsigned IDX_W = 16;

  ld_state_e              state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [15:0]            len_q, len_d;
  logic [7:0]             lo_q, lo_d;
  logic [7:0]             csum_q, csum_d;
  logic                   we_q, we_d;
  logic [ADDR_W-1:0]      waddr_q, waddr_d;
  logic [Z16_INSTR_W-1:0] wdata_q, wdata_d;

  logic                   accept;
  logic [7:0]             csum_sum;
  logic [15:0]            len_new;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= LD_LEN_LO;
      idx_q   <= '0;
      len_q   <= '0;
      lo_q    <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      lo_q    <= lo_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign o_ready  = (state_q != LD_DONE) && (state_q != LD_ERR);
  assign accept   = i_valid && o_ready;
  assign csum_sum = csum_q + i_data;
  assign len_new  = {i_data, len_q[7:0]};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    lo_d    = lo_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    if (accept) csum_d = csum_sum;

    case (state_q)
      LD_LEN_LO: if (accept) begin
        len_d   = {len_q[15:8], i_data};
        state_d = LD_LEN_HI;
      end
      LD_LEN_HI: if (accept) begin
        len_d = len_new;
        // Oversized frames are rejected before any RAM write is issued.
        if (32'(len_new) > MAX_WORDS) state_d = LD_ERR;
        else if (len_new == 16'd0)    state_d = LD_CSUM;
        else                          state_d = LD_DAT_LO;
      end
      LD_DAT_LO: if (accept) begin
        lo_d    = i_data;
        state_d = LD_DAT_HI;
      end
      LD_DAT_HI: if (accept) begin
        we_d    = 1'b1;
        wdata_d = {i_data, lo_q};
        waddr_d = ADDR_W'({idx_q, 1'b0});
        idx_d   = idx_q + 1'b1;
        state_d = (idx_q == len_q - 16'd1) ? LD_CSUM : LD_DAT_LO;
      end
      LD_CSUM: if (accept) begin
        state_d = (csum_sum == 8'h00) ? LD_DONE : LD_ERR;
      end
      LD_DONE, LD_ERR: if (i_restart) begin
        state_d = LD_LEN_LO;
        idx_d   = '0;
        csum_d  = '0;
      end
      default: state_d = LD_LEN_LO;
    endcase
  end

  assign o_we      = we_q;
  assign o_waddr   = waddr_q;
  assign o_wdata   = wdata_q;
  assign o_done    = (state_q == LD_DONE);
  assign o_err     = (state_q == LD_ERR);
  assign o_cpu_rst = (state_q != LD_DONE);

endmodule

// File: tb/tb_z16_program_loader.sv
// Directed bench for z16_program_loader: good/bad frames, empty and oversized frames,
// idle gaps, and reset in the middle of a word.
module tb_z16_program_loader;

  logic        clk = 1'b0;
  logic        i_rst, i_valid, i_restart;
  logic [7:0]  i_data;
  logic        o_ready, o_we, o_cpu_rst, o_done, o_err;
  logic [15:0] o_waddr, o_wdata;

  int checks = 0;
  int errors = 0;

  logic [15:0] wa[$];
  logic [15:0] wd[$];

  logic [7:0]  f1[16] = '{8'h07, 8'h00, 8'h10, 8'h00, 8'h20, 8'h00, 8'h19, 8'h0A,
                          8'h20, 8'h12, 8'h19, 8'hFF, 8'h4F, 8'hFC, 8'hFD, 8'h00};
  logic [15:0] exp_wd[7] = '{16'h0010, 16'h0020, 16'h0A19, 16'h1220,
                             16'hFF19, 16'hFC4F, 16'h00FD};
  // Bytes above sum to 0xEC, so 0x14 brings the running sum to zero.
  logic [7:0]  good_cs = 8'h14;

  always #5 clk = ~clk;

  z16_program_loader #(.MAX_WORDS(1024), .ADDR_W(16)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .i_restart(i_restart), .o_we(o_we), .o_waddr(o_waddr),
    .o_wdata(o_wdata), .o_cpu_rst(o_cpu_rst), .o_done(o_done), .o_err(o_err)
  );

  always @(negedge clk) if (o_we) begin
    wa.push_back(o_waddr);
    wd.push_back(o_wdata);
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      while ($urandom_range(0, 9) < 3) begin
        i_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    i_valid = 1'b1;
    i_data  = b;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic send_frame1(input logic [7:0] cs, input bit gaps);
    for (int i = 0; i < 16; i++) send_byte(f1[i], gaps);
    send_byte(cs, gaps);
  endtask

  task automatic pulse_restart();
    i_restart = 1'b1;
    @(posedge clk); #1;
    i_restart = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_valid = 1'b0; i_restart = 1'b0; i_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 i_rst = 1'b0;
    checks++;
    if ({o_ready, o_cpu_rst, o_done, o_err, o_we} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 11000", {o_ready, o_cpu_rst, o_done, o_err, o_we});
    end
    checks++;
    if ({o_waddr, o_wdata} !== 32'h0) begin
      errors++;
      $display("FAIL reset_wport got %h exp 00000000", {o_waddr, o_wdata});
    end
  endtask

  task automatic test_good_frame();
    wa.delete(); wd.delete();
    send_frame1(good_cs, 1'b0);
    checks++;
    if ({o_done, o_err, o_cpu_rst, o_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL good_flags got %b exp 1000", {o_done, o_err, o_cpu_rst, o_ready});
    end
    checks++;
    if (wa.size() != 7) begin
      errors++;
      $display("FAIL good_nwrites got %0d exp 7", wa.size());
    end
    for (int i = 0; i < 7 && i < wa.size(); i++) begin
      checks++;
      if (wa[i] !== 16'(2 * i) || wd[i] !== exp_wd[i]) begin
        errors++;
        $display("FAIL good_write[%0d] got %h/%h exp %h/%h", i, wa[i], wd[i], 16'(2 * i), exp_wd[i]);
      end
    end
    checks++;
    if ({o_we, o_waddr, o_wdata} !== {1'b0, 16'h000C, 16'h00FD}) begin
      errors++;
      $display("FAIL good_hold got %b %h %h exp 0 000c 00fd", o_we, o_waddr, o_wdata);
    end
    pulse_restart();
    checks++;
    if ({o_ready, o_cpu_rst, o_done, o_err} !== 4'b1100) begin
      errors++;
      $display("FAIL restart_flags got %b exp 1100", {o_ready, o_cpu_rst, o_done, o_err});
    end
  endtask

  task automatic test_bad_csum();
    wa.delete(); wd.delete();
    send_frame1(good_cs + 8'h01, 1'b0);
    checks++;
    if ({o_err, o_done, o_cpu_rst, o_ready} !== 4'b1010) begin
      errors++;
      $display("FAIL badcs_flags got %b exp 1010", {o_err, o_done, o_cpu_rst, o_ready});
    end
    checks++;
    if (wa.size() != 7) begin
      errors++;
      $display("FAIL badcs_nwrites got %0d exp 7", wa.size());
    end
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    checks++;
    if ({o_err, o_ready, o_we} !== 3'b100) begin
      errors++;
      $display("FAIL badcs_drop got %b exp 100", {o_err, o_ready, o_we});
    end
    pulse_restart();
  endtask

  task automatic test_empty_frame();
    wa.delete(); wd.delete();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    checks++;
    if (o_done !== 1'b0) begin
      errors++;
      $display("FAIL empty_early got %b exp 0", o_done);
    end
    send_byte(8'h00, 1'b0);
    checks++;
    if ({o_done, o_err, o_cpu_rst} !== 3'b100) begin
      errors++;
      $display("FAIL empty_done got %b exp 100", {o_done, o_err, o_cpu_rst});
    end
    checks++;
    if (wa.size() != 0) begin
      errors++;
      $display("FAIL empty_nwrites got %0d exp 0", wa.size());
    end
    pulse_restart();
  endtask

  task automatic test_oversize();
    wa.delete(); wd.delete();
    send_byte(8'h01, 1'b0);
    send_byte(8'h04, 1'b0);
    checks++;
    if ({o_err, o_ready, o_cpu_rst} !== 3'b101) begin
      errors++;
      $display("FAIL oversize_err got %b exp 101", {o_err, o_ready, o_cpu_rst});
    end
    send_byte(8'h10, 1'b0);
    send_byte(8'h00, 1'b0);
    checks++;
    if (wa.size() != 0) begin
      errors++;
      $display("FAIL oversize_nwrites got %0d exp 0", wa.size());
    end
    pulse_restart();
    send_frame1(good_cs, 1'b0);
    checks++;
    if ({o_done, wa.size() == 7} !== 2'b11) begin
      errors++;
      $display("FAIL oversize_reload got done=%b writes=%0d exp done=1 writes=7", o_done, wa.size());
    end
    pulse_restart();
  endtask

  task automatic test_gaps();
    wa.delete(); wd.delete();
    send_frame1(good_cs, 1'b1);
    checks++;
    if ({o_done, o_err, o_cpu_rst} !== 3'b100) begin
      errors++;
      $display("FAIL gaps_flags got %b exp 100", {o_done, o_err, o_cpu_rst});
    end
    checks++;
    if (wa.size() != 7) begin
      errors++;
      $display("FAIL gaps_nwrites got %0d exp 7", wa.size());
    end
    for (int i = 0; i < 7 && i < wa.size(); i++) begin
      checks++;
      if (wa[i] !== 16'(2 * i) || wd[i] !== exp_wd[i]) begin
        errors++;
        $display("FAIL gaps_write[%0d] got %h/%h exp %h/%h", i, wa[i], wd[i], 16'(2 * i), exp_wd[i]);
      end
    end
    pulse_restart();
  endtask

  task automatic test_mid_reset();
    wa.delete(); wd.delete();
    for (int i = 0; i < 9; i++) send_byte(f1[i], 1'b0);
    i_rst = 1'b1; i_valid = 1'b1; i_data = f1[9];
    @(posedge clk); #1;
    i_rst = 1'b0; i_valid = 1'b0;
    checks++;
    if ({o_we, o_ready, o_cpu_rst, o_done, o_err, o_waddr, o_wdata} !== {5'b01100, 32'h0}) begin
      errors++;
      $display("FAIL midrst_outputs got %b %h %h exp 01100 0000 0000",
               {o_we, o_ready, o_cpu_rst, o_done, o_err}, o_waddr, o_wdata);
    end
    checks++;
    if (wa.size() != 3) begin
      errors++;
      $display("FAIL midrst_nwrites got %0d exp 3", wa.size());
    end
    wa.delete(); wd.delete();
    send_frame1(good_cs, 1'b0);
    checks++;
    if (wa.size() == 0 || wa[0] !== 16'h0000 || wd[0] !== 16'h0010) begin
      errors++;
      $display("FAIL midrst_reload_first got n=%0d exp first write 0000/0010", wa.size());
    end
    checks++;
    if ({o_done, wa.size() == 7} !== 2'b11) begin
      errors++;
      $display("FAIL midrst_reload_done got done=%b writes=%0d exp done=1 writes=7", o_done, wa.size());
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_empty_frame();
    test_oversize();
    test_gaps();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
